xor_crypt_pipe_multikey: RTL

- Parametrised successor to the single-byte, three-key XOR crypt stage.
- Holds NUM_KEYS programmable keys of DATA_W bits and XORs each accepted beat with the current key.
- The key rotates after every rot_freq+1 accepted beats. XOR is symmetric, so the same block serves the encrypt and decrypt paths.
- Adds valid/ready flow control with a one-stage registered output, a bypass mode, a key-load port and a synchronous resync.

---
 rtl/xor_crypt_pipe_multikey.sv | 116 +++++++++++
 1 files changed

// File: rtl/xor_crypt_pipe_multikey.sv
// rtl/xor_crypt_pipe_multikey.sv - rotating multi-key XOR crypt stage with valid/ready and one output register
// Optional build macro XOR_CRYPT_PIPE_PARITY_EN adds out_parity (even parity of out_data).
module xor_crypt_pipe_multikey #(
  parameter int DATA_W   = 8,
  parameter int NUM_KEYS = 3,
  parameter int CNT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        mode,
  input  logic [CNT_W-1:0]            rot_freq,
  input  logic                        resync,
  input  logic                        key_wr_en,
  input  logic [$clog2(NUM_KEYS)-1:0] key_wr_idx,
  input  logic [DATA_W-1:0]           key_wr_data
`ifdef XOR_CRYPT_PIPE_PARITY_EN
  ,
  output logic                        out_parity
`endif
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  logic [DATA_W-1:0] key_q [NUM_KEYS];
  logic [IDX_W-1:0]  key_idx_q, key_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              accept;
  logic              key_wr_hit;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign key_wr_hit = key_wr_en && (int'(key_wr_idx) < NUM_KEYS);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // Key registers: a same-cycle beat still reads the old value, the write lands at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
    end else if (key_wr_hit) begin
      key_q[key_wr_idx] <= key_wr_data;
    end
  end

  // Rotation bookkeeping: advance only on XOR-mode accepts; resync wins over rotation.
  always_comb begin
    cnt_d     = cnt_q;
    key_idx_d = key_idx_q;
    if (accept && mode) begin
      if (cnt_q >= rot_freq) begin
        cnt_d     = '0;
        key_idx_d = (key_idx_q == LAST_IDX) ? '0 : key_idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (resync) begin
      cnt_d     = '0;
      key_idx_d = '0;
    end
  end

  // Output slot: load on accept, empty after a transfer, otherwise hold stable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mode ? (in_data ^ key_q[key_idx_q]) : in_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers for rotation and the output slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      key_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      key_idx_q   <= key_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef XOR_CRYPT_PIPE_PARITY_EN
  logic out_parity_q;

  // Parity travels with out_data: loaded on accept, held through stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_parity_q <= 1'b0;
    end else if (accept) begin
      out_parity_q <= ^out_data_d;
    end
  end

  assign out_parity = out_parity_q;
`else
  // Without the parity option the output slot carries data only.
`endif

endmodule
